dm_sba_arbiter: RTL and testbench
=================================

DM_SBA_ARBITER -- requirements
Module: dm_sba_arbiter

Interface
REQ-001 SHALL have parameter NrHosts, default 2, number of bus hosts sharing one device port (index 0 = debug-module SBA host, 1 = core data host).
REQ-002 SHALL have parameter BusWidth, default 32, address/data width.
REQ-003 SHALL have parameter MaxOutstanding, default 2, maximum granted-but-unanswered transactions (power of two, >=1).
REQ-004 SHALL have port clk_i  input  1  sole clock.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port host_req_i  input  NrHosts  per-host request.
REQ-007 SHALL have port host_we_i  input  NrHosts  per-host write enable.
REQ-008 SHALL have port host_addr_i  input  NrHosts x BusWidth  per-host address.
REQ-009 SHALL have port host_be_i  input  NrHosts x BusWidth/8  per-host byte enables.
REQ-010 SHALL have port host_wdata_i  input  NrHosts x BusWidth  per-host write data.
REQ-011 SHALL have port host_gnt_o  output  NrHosts  per-host grant, one-hot or zero.
REQ-012 SHALL have port host_rvalid_o  output  NrHosts  per-host response valid, one-hot or zero.
REQ-013 SHALL have port host_rdata_o  output  BusWidth  response data, broadcast to all hosts.
REQ-014 SHALL have ports dev_req_o, dev_we_o (1), dev_addr_o, dev_wdata_o (BusWidth), dev_be_o (BusWidth/8)  output  device-side request.
REQ-015 SHALL have ports dev_gnt_i, dev_rvalid_i (1), dev_rdata_i (BusWidth)  input  device grant and response.
REQ-016 SHALL have port unexp_rvalid_o  output  1  one-cycle pulse on a response with no outstanding transaction.

Function
REQ-017 Handshake SHALL be req/gnt: a transfer occurs in a cycle with dev_req_o=1 and dev_gnt_i=1; exactly one response (dev_rvalid_i) per transfer, in order, at least one cycle after the grant.
REQ-018 Arbiter SHALL be round-robin: highest priority is the host after the last granted host (modulo NrHosts); after reset, host 0 has highest priority.
REQ-019 State SHALL be IDLE (no host selected) or LOCKED (selection held): IDLE->LOCKED when dev_req_o=1 and dev_gnt_i=0; LOCKED->IDLE on dev_gnt_i=1.
REQ-020 In LOCKED, selected host SHALL not change even if a higher-priority host requests; selected host's request fields SHALL pass through unchanged.
REQ-021 dev_req_o, dev_we_o, dev_addr_o, dev_be_o, dev_wdata_o SHALL be combinational muxes of the selected host's inputs; unselected outputs SHALL be 0.
REQ-022 host_gnt_o[sel] SHALL equal dev_req_o & dev_gnt_i; all other grant bits 0.
REQ-023 Each transfer SHALL push the granted host index into an owner FIFO of depth MaxOutstanding; each dev_rvalid_i SHALL pop it and assert host_rvalid_o[head] for that same cycle.
REQ-024 host_rdata_o SHALL equal dev_rdata_i combinationally.
REQ-025 When the owner FIFO is full, dev_req_o SHALL be 0 unless dev_rvalid_i=1 in the same cycle (simultaneous pop frees a slot).
REQ-026 Push and pop in the same cycle SHALL keep the count unchanged; with FIFO empty, a same-cycle grant and rvalid SHALL treat the rvalid as unexpected.
REQ-027 dev_rvalid_i with FIFO empty SHALL drive no host_rvalid_o bit and SHALL pulse unexp_rvalid_o for one cycle.
REQ-028 Round-robin pointer SHALL update only on a completed transfer.

Reset
REQ-029 While rst_ni=0, SHALL drive dev_req_o=0, host_gnt_o=0, host_rvalid_o=0, unexp_rvalid_o=0, state=IDLE, FIFO empty, priority pointer=host 0.
REQ-030 Reset asserted mid-transaction SHALL discard all outstanding owners; responses arriving after reset release SHALL be flagged via unexp_rvalid_o.

Verification
REQ-031 Host 0 and host 1 request together from reset, dev_gnt_i=1 -> grant sequence 0,1,0,1 over four transfers.
REQ-032 Host 1 request, dev_gnt_i=0 for 3 cycles, host 0 raises req in cycle 2 -> dev_addr_o stays host 1 address until grant; host 0 granted next.
REQ-033 Host 0 issues two grants without responses (MaxOutstanding=2) -> dev_req_o=0 on a third request; goes high in the cycle dev_rvalid_i=1.
REQ-034 Grants to hosts 1 then 0, responses with rdata 0xAAAA_0001 then 0xBBBB_0002 -> host_rvalid_o=2'b10 then 2'b01 with matching rdata.
REQ-035 dev_rvalid_i=1 with nothing outstanding -> host_rvalid_o=0, unexp_rvalid_o=1 for one cycle.
REQ-036 rst_ni pulsed low with one outstanding, then response -> no host_rvalid_o, unexp_rvalid_o=1, next arbitration starts at host 0.

Source files
------------

// File: rtl/dm_sba_arbiter.sv
// dm_sba_arbiter: round-robin req/gnt arbiter sharing one device port among NrHosts bus hosts,
// with an owner FIFO that routes in-order responses back to the host that issued each transfer.
module dm_sba_arbiter #(
  parameter int NrHosts        = 2,
  parameter int BusWidth       = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NrHosts-1:0]                    host_req_i,
  input  logic [NrHosts-1:0]                    host_we_i,
  input  logic [NrHosts-1:0][BusWidth-1:0]      host_addr_i,
  input  logic [NrHosts-1:0][BusWidth/8-1:0]    host_be_i,
  input  logic [NrHosts-1:0][BusWidth-1:0]      host_wdata_i,
  output logic [NrHosts-1:0]                    host_gnt_o,
  output logic [NrHosts-1:0]                    host_rvalid_o,
  output logic [BusWidth-1:0]                   host_rdata_o,
  output logic                                  dev_req_o,
  output logic                                  dev_we_o,
  output logic [BusWidth-1:0]                   dev_addr_o,
  output logic [BusWidth-1:0]                   dev_wdata_o,
  output logic [BusWidth/8-1:0]                 dev_be_o,
  input  logic                                  dev_gnt_i,
  input  logic                                  dev_rvalid_i,
  input  logic [BusWidth-1:0]                   dev_rdata_i,
  output logic                                  unexp_rvalid_o
);
  localparam int IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  typedef enum logic {IDLE, LOCKED} state_e;
  state_e          r_state;
  logic [IdxW-1:0] r_sel, r_rr;
  logic [IdxW-1:0] r_owner [MaxOutstanding];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_cnt;
  logic [IdxW-1:0] w_sel;
  logic            w_sel_req, w_full, w_empty, w_xfer, w_pop;
  // Reverse scan so the host closest after the pointer is the last (winning) assignment.
  always_comb begin
    w_sel     = r_sel;
    w_sel_req = 1'b0;
    if (r_state == LOCKED) begin
      w_sel_req = host_req_i[r_sel];
    end else begin
      for (int i = NrHosts - 1; i >= 0; i--) begin
        if (host_req_i[(int'(r_rr) + i) % NrHosts]) begin
          w_sel     = IdxW'((int'(r_rr) + i) % NrHosts);
          w_sel_req = 1'b1;
        end
      end
    end
  end
  assign w_full  = (r_cnt == CntW'(MaxOutstanding));
  assign w_empty = (r_cnt == '0);
  // A full owner FIFO only admits a new transfer when a response frees a slot this cycle.
  assign dev_req_o      = rst_ni & w_sel_req & (~w_full | dev_rvalid_i);
  assign dev_we_o       = dev_req_o & host_we_i[w_sel];
  assign dev_addr_o     = dev_req_o ? host_addr_i[w_sel]  : '0;
  assign dev_wdata_o    = dev_req_o ? host_wdata_i[w_sel] : '0;
  assign dev_be_o       = dev_req_o ? host_be_i[w_sel]    : '0;
  assign w_xfer         = dev_req_o & dev_gnt_i;
  assign w_pop          = rst_ni & dev_rvalid_i & ~w_empty;
  assign unexp_rvalid_o = rst_ni & dev_rvalid_i & w_empty;
  assign host_rdata_o   = dev_rdata_i;
  always_comb begin
    host_gnt_o                    = '0;
    host_gnt_o[w_sel]             = w_xfer;
    host_rvalid_o                 = '0;
    host_rvalid_o[r_owner[r_rptr]] = w_pop;
  end
  always_ff @(posedge clk_i) begin
    if (w_xfer) r_owner[r_wptr] <= w_sel;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_rr    <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
    end else begin
      if (r_state == IDLE && dev_req_o && !dev_gnt_i) begin
        r_state <= LOCKED;
        r_sel   <= w_sel;
      end else if (r_state == LOCKED && dev_gnt_i) begin
        r_state <= IDLE;
      end
      if (w_xfer) begin
        r_wptr <= (r_wptr == PtrW'(MaxOutstanding - 1)) ? '0 : r_wptr + 1'b1;
        r_rr   <= (w_sel == IdxW'(NrHosts - 1)) ? '0 : w_sel + 1'b1;
      end
      if (w_pop) r_rptr <= (r_rptr == PtrW'(MaxOutstanding - 1)) ? '0 : r_rptr + 1'b1;
      r_cnt <= r_cnt + CntW'(w_xfer) - CntW'(w_pop);
    end
  end
endmodule

// File: tb/tb_dm_sba_arbiter.sv
// tb_dm_sba_arbiter: directed scenarios plus randomized traffic, all checked against a
// queue-based reference model of round-robin arbitration and in-order response routing.
module tb_dm_sba_arbiter;
  localparam int N  = 2;
  localparam int BW = 32;
  localparam int MO = 2;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  logic [N-1:0]            req, we, gnt_o, rv_o;
  logic [N-1:0][BW-1:0]    addr, wdata;
  logic [N-1:0][BW/8-1:0]  be;
  logic [BW-1:0]           rdata_o, d_addr, d_wdata, d_rdata;
  logic [BW/8-1:0]         d_be;
  logic                    d_req, d_we, d_gnt, d_rv, unexp;
  dm_sba_arbiter #(.NrHosts(N), .BusWidth(BW), .MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .host_req_i(req), .host_we_i(we), .host_addr_i(addr),
    .host_be_i(be), .host_wdata_i(wdata), .host_gnt_o(gnt_o), .host_rvalid_o(rv_o),
    .host_rdata_o(rdata_o), .dev_req_o(d_req), .dev_we_o(d_we), .dev_addr_o(d_addr),
    .dev_wdata_o(d_wdata), .dev_be_o(d_be), .dev_gnt_i(d_gnt), .dev_rvalid_i(d_rv),
    .dev_rdata_i(d_rdata), .unexp_rvalid_o(unexp)
  );
  int n_chk = 0;
  int n_err = 0;
  int m_rr, m_sel;
  bit m_lock;
  int m_q[$];
  logic [N-1:0]  s_gnt, s_rv;
  logic          s_req, s_unexp;
  logic [BW-1:0] s_addr, s_rdata;
  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic rnd_data();
    for (int h = 0; h < N; h++) begin
      addr[h]  = $urandom;
      wdata[h] = $urandom;
      be[h]    = BW/8'($urandom);
      we[h]    = 1'($urandom);
    end
    d_rdata = $urandom;
  endtask
  // Called just after a falling edge with inputs set; checks, then advances the model past the rising edge.
  task automatic cyc();
    int  sel;
    bit  sreq, dreq, xfer, pop;
    sel = m_sel;
    sreq = 0;
    if (m_lock) sreq = req[m_sel];
    else
      for (int k = 0; k < N && !sreq; k++)
        if (req[(m_rr + k) % N]) begin
          sel  = (m_rr + k) % N;
          sreq = 1;
        end
    dreq = sreq && (m_q.size() < MO || d_rv);
    xfer = dreq && d_gnt;
    pop  = d_rv && m_q.size() > 0;
    #1;
    check("dev_req", BW'(d_req), BW'(dreq));
    check("dev_we", BW'(d_we), dreq ? BW'(we[sel]) : '0);
    check("dev_addr", d_addr, dreq ? addr[sel] : '0);
    check("dev_wdata", d_wdata, dreq ? wdata[sel] : '0);
    check("dev_be", BW'(d_be), dreq ? BW'(be[sel]) : '0);
    check("host_gnt", BW'(gnt_o), xfer ? BW'(1) << sel : '0);
    check("host_rvalid", BW'(rv_o), pop ? BW'(1) << m_q[0] : '0);
    check("unexp", BW'(unexp), BW'(d_rv && m_q.size() == 0));
    check("rdata", rdata_o, d_rdata);
    {s_gnt, s_rv, s_req, s_unexp, s_addr, s_rdata} = {gnt_o, rv_o, d_req, unexp, d_addr, rdata_o};
    if (pop) void'(m_q.pop_front());
    if (xfer) begin
      m_q.push_back(sel);
      m_rr = (sel + 1) % N;
    end
    if (!m_lock && dreq && !d_gnt) begin
      m_lock = 1;
      m_sel  = sel;
    end else if (m_lock && d_gnt) m_lock = 0;
    @(negedge clk);
    rnd_data();
  endtask
  task automatic quiet();
    req = '0; d_gnt = 0; d_rv = 0;
  endtask
  task automatic do_reset();
    req = '1; d_rv = 1; d_gnt = 1;
    rst_n = 0;
    #1;
    check("rst_req", BW'(d_req), '0);
    check("rst_gnt", BW'(gnt_o), '0);
    check("rst_rv", BW'(rv_o), '0);
    check("rst_unexp", BW'(unexp), '0);
    m_rr = 0; m_sel = 0; m_lock = 0; m_q.delete();
    @(negedge clk);
    rst_n = 1;
    quiet();
  endtask
  initial begin
    logic [N-1:0] seq [4];
    logic [BW-1:0] a1;
    seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst_n = 1;
    quiet();
    rnd_data();
    @(negedge clk);
    do_reset();
    // Both hosts requesting alternate strictly.
    for (int i = 0; i < 4; i++) begin
      req = 2'b11; d_gnt = 1; d_rv = m_q.size() > 0;
      cyc();
      check("rr_seq", BW'(s_gnt), BW'(seq[i]));
    end
    do_reset();
    // Held selection while the device stalls.
    for (int i = 0; i < 3; i++) begin
      req = (i >= 1) ? 2'b11 : 2'b10; d_gnt = 0;
      a1 = addr[1];
      cyc();
      check("lock_addr", s_addr, a1);
    end
    req = 2'b11; d_gnt = 1;
    cyc();
    check("lock_gnt1", BW'(s_gnt), BW'(2'b10));
    cyc();
    check("next_gnt0", BW'(s_gnt), BW'(2'b01));
    do_reset();
    // Outstanding limit and same-cycle pop.
    req = 2'b01; d_gnt = 1;
    cyc(); cyc();
    cyc();
    check("full_block", BW'(s_req), '0);
    d_rv = 1;
    cyc();
    check("full_pop_req", BW'(s_req), 1);
    do_reset();
    // Responses routed to their owners in order.
    req = 2'b10; d_gnt = 1; cyc();
    req = 2'b01; cyc();
    quiet(); d_rv = 1; d_rdata = 32'hAAAA_0001; cyc();
    check("own_rv1", BW'(s_rv), BW'(2'b10));
    check("own_rd1", s_rdata, 32'hAAAA_0001);
    d_rv = 1; d_rdata = 32'hBBBB_0002; cyc();
    check("own_rv2", BW'(s_rv), BW'(2'b01));
    check("own_rd2", s_rdata, 32'hBBBB_0002);
    do_reset();
    // Response with nothing outstanding.
    d_rv = 1; cyc();
    check("unexp_rv", BW'(s_rv), '0);
    check("unexp_hi", BW'(s_unexp), 1);
    d_rv = 0; cyc();
    check("unexp_lo", BW'(s_unexp), '0);
    // Reset discards an outstanding owner and the pointer.
    req = 2'b01; d_gnt = 1; cyc();
    do_reset();
    d_rv = 1; cyc();
    check("post_rst_unexp", BW'(s_unexp), 1);
    check("post_rst_rv", BW'(s_rv), '0);
    quiet(); req = 2'b11; d_gnt = 1; cyc();
    check("post_rst_gnt", BW'(s_gnt), BW'(2'b01));
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      req   = N'($urandom);
      d_gnt = 1'($urandom);
      d_rv  = (m_q.size() > 0) ? 1'($urandom) : ($urandom_range(0, 7) == 0);
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
